// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD MM:SS countdown timer.
package bcd_timer_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // Saturate a preset nibble so out-of-range values never reach the count.
    function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] d,
                                                   input logic [BCD_W-1:0] max_val);
        return (d > max_val) ? max_val : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown borrow chain; wraps 0 -> i_max when borrowed from.
module bcd_digit_down
    import bcd_timer_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    input  logic [BCD_W-1:0] i_max,
    input  logic             i_borrow,
    output logic [BCD_W-1:0] o_digit,
    output logic             o_borrow
);

    logic w_is_zero;

    assign w_is_zero = (i_digit == '0);
    assign o_borrow  = i_borrow & w_is_zero;

    always_comb begin
        o_digit = i_digit;
        if (i_borrow) begin
            o_digit = w_is_zero ? i_max : (i_digit - 1'b1);
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD MM:SS countdown timer with load/start/pause control and done pulse.
// Define BCD_TIMER_AUTO_RELOAD_EN to reload the preset on expiry instead of stopping.
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int CLK_DIV = 50000000
) (
    input  logic             rst,
    input  logic             in_clk,
    input  logic             load,
    input  logic             start,
    input  logic             pause,
    input  logic [BCD_W-1:0] preset_min_tens,
    input  logic [BCD_W-1:0] preset_min_ones,
    input  logic [BCD_W-1:0] preset_sec_tens,
    input  logic [BCD_W-1:0] preset_sec_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             running,
    output logic             paused,
    output logic             expired,
    output logic             done
);

    localparam int PRESC_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    // Digit arrays are ordered least significant first: sec_ones, sec_tens, min_ones, min_tens.
    state_t             r_state;
    logic [PRESC_W-1:0] r_presc;
    logic [BCD_W-1:0]   r_digit  [4];
    logic [BCD_W-1:0]   r_preset [4];
    logic               r_running, r_paused, r_expired, r_done;

    state_t             w_state_next;
    logic [PRESC_W-1:0] w_presc_next;
    logic [BCD_W-1:0]   w_digit_next  [4];
    logic [BCD_W-1:0]   w_preset_next [4];
    logic               w_done_next;
    logic [BCD_W-1:0]   w_raw     [4];
    logic [BCD_W-1:0]   w_clamped [4];
    logic [BCD_W-1:0]   w_dec     [4];
    logic [4:0]         w_borrow;
    logic               w_count_zero;
    logic               w_dec_zero;

    assign w_raw[0] = preset_sec_ones;
    assign w_raw[1] = preset_sec_tens;
    assign w_raw[2] = preset_min_ones;
    assign w_raw[3] = preset_min_tens;

    assign w_borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [BCD_W-1:0] MAXV = (gi == 1) ? SEC_TENS_MAX : DIGIT_MAX;

            assign w_clamped[gi] = clamp_bcd(w_raw[gi], MAXV);

            bcd_digit_down u_digit (
                .i_digit  (r_digit[gi]),
                .i_max    (MAXV),
                .i_borrow (w_borrow[gi]),
                .o_digit  (w_dec[gi]),
                .o_borrow (w_borrow[gi+1])
            );
        end
    endgenerate

    // A borrow out of the top digit means every digit was already zero.
    assign w_count_zero = w_borrow[4];
    assign w_dec_zero   = ((w_dec[0] | w_dec[1] | w_dec[2] | w_dec[3]) == '0);

    always_comb begin
        w_state_next  = r_state;
        w_presc_next  = r_presc;
        w_digit_next  = r_digit;
        w_preset_next = r_preset;
        w_done_next   = 1'b0;
        if (load) begin
            w_digit_next  = w_clamped;
            w_preset_next = w_clamped;
            w_presc_next  = '0;
            w_state_next  = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!pause && start && !w_count_zero) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        w_state_next = ST_PAUSE;
                    end else if (r_presc == PRESC_LAST) begin
                        w_presc_next = '0;
                        w_digit_next = w_dec;
                        if (w_dec_zero) begin
                            w_done_next = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                            w_digit_next = r_preset;
`else
                            w_state_next = ST_EXPIRED;
`endif
                        end
                    end else begin
                        w_presc_next = r_presc + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (!pause && start) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_digit   <= '{default: '0};
            r_preset  <= '{default: '0};
            r_running <= 1'b0;
            r_paused  <= 1'b0;
            r_expired <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_presc   <= w_presc_next;
            r_digit   <= w_digit_next;
            r_preset  <= w_preset_next;
            r_running <= (w_state_next == ST_RUN);
            r_paused  <= (w_state_next == ST_PAUSE);
            r_expired <= (w_state_next == ST_EXPIRED);
            r_done    <= w_done_next;
        end
    end

    assign sec_ones = r_digit[0];
    assign sec_tens = r_digit[1];
    assign min_ones = r_digit[2];
    assign min_tens = r_digit[3];
    assign running  = r_running;
    assign paused   = r_paused;
    assign expired  = r_expired;
    assign done     = r_done;

endmodule
